// File: rtl/router_read_scheduler.sv
// Round-robin drain of the three router FIFOs into one framed byte stream (sop/eop/port, pre-ready pacing).
// Optional running-parity check of each packet, enabled by defining ROUTER_RDSCHED_PARITY_CHECK_EN.
module router_read_scheduler #(
    parameter int LEN_W       = 6,
    parameter int STALL_LIMIT = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic [7:0] data_out_0,
    input  logic [7:0] data_out_1,
    input  logic [7:0] data_out_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] out_port,
    output logic       rd_busy,
    output logic       abort,
    output logic       parity_err
);

    localparam int CNT_W   = LEN_W + 1;
    localparam int STALL_W = 8;
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_ONE = {{(STALL_W-1){1'b0}}, 1'b1};
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT - 32'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_HWAIT = 3'd2,
        S_BODY  = 3'd3,
        S_TAIL  = 3'd4
    } state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    state_e             state_q, state_d;
    logic [1:0]         port_q, port_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               pend_q, pend_d;

    logic [2:0] empty_v_s;
    logic [1:0] cand1_s, cand2_s, cand3_s;
    logic       g_empty_s, g_srst_s;
    logic [7:0] g_data_s;
    logic       rd_s, abort_s, valid_s, sop_s, eop_s, perr_s;

    assign empty_v_s = {empty_2, empty_1, empty_0};
    assign cand1_s   = rr_next(last_q);
    assign cand2_s   = rr_next(cand1_s);
    assign cand3_s   = rr_next(cand2_s);

    // Route the granted FIFO's flags and data
    always_comb begin
        g_empty_s = 1'b1;
        g_srst_s  = 1'b0;
        g_data_s  = 8'h00;
        case (port_q)
            2'd0: begin g_empty_s = empty_0; g_srst_s = soft_reset_0; g_data_s = data_out_0; end
            2'd1: begin g_empty_s = empty_1; g_srst_s = soft_reset_1; g_data_s = data_out_1; end
            2'd2: begin g_empty_s = empty_2; g_srst_s = soft_reset_2; g_data_s = data_out_2; end
            default: begin g_empty_s = 1'b1; g_srst_s = 1'b0; g_data_s = 8'h00; end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            port_q  <= 2'd0;
            last_q  <= 2'd2;
            rem_q   <= '0;
            stall_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic; pend tracks that a byte returns next cycle
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        rem_d   = rem_q;
        stall_d = stall_q;
        pend_d  = rd_s;
        case (state_q)
            S_IDLE: begin
                rem_d   = '0;
                stall_d = '0;
                if (!empty_v_s[cand1_s]) begin
                    port_d = cand1_s; state_d = S_HDR;
                end else if (!empty_v_s[cand2_s]) begin
                    port_d = cand2_s; state_d = S_HDR;
                end else if (!empty_v_s[cand3_s]) begin
                    port_d = cand3_s; state_d = S_HDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (abort_s) begin
                    state_d = S_IDLE; last_d = port_q;
                end else if (rd_s) begin
                    state_d = S_HWAIT;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_HWAIT: begin
                if (abort_s) begin
                    state_d = S_IDLE; last_d = port_q;
                end else begin
                    rem_d   = {{(CNT_W-LEN_W){1'b0}}, g_data_s[2 +: LEN_W]} + CNT_ONE;
                    state_d = S_BODY;
                end
            end
            S_BODY: begin
                if (abort_s) begin
                    state_d = S_IDLE; last_d = port_q;
                end else if (rd_s) begin
                    rem_d   = rem_q - CNT_ONE;
                    stall_d = '0;
                    state_d = (rem_q == CNT_ONE) ? S_TAIL : S_BODY;
                end else if (g_empty_s && (rem_q != '0)) begin
                    stall_d = stall_q + STALL_ONE;
                end else begin
                    stall_d = stall_q;
                end
            end
            S_TAIL: begin
                state_d = S_IDLE;
                last_d  = port_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read strobes, framing and abort decisions
    always_comb begin
        rd_s    = 1'b0;
        abort_s = 1'b0;
        valid_s = 1'b0;
        sop_s   = 1'b0;
        eop_s   = 1'b0;
        case (state_q)
            S_IDLE: rd_s = 1'b0;
            S_HDR: begin
                if (g_srst_s) abort_s = 1'b1;
                else          rd_s    = out_ready && !g_empty_s;
            end
            S_HWAIT: begin
                if (g_srst_s) begin
                    abort_s = 1'b1;
                end else begin
                    valid_s = pend_q;
                    sop_s   = pend_q;
                end
            end
            S_BODY: begin
                if (g_srst_s) begin
                    abort_s = 1'b1;
                end else begin
                    valid_s = pend_q;
                    if (g_empty_s && (rem_q != '0)) abort_s = (stall_q >= STALL_MAX);
                    else                            rd_s    = out_ready && !g_empty_s && (rem_q != '0);
                end
            end
            S_TAIL: begin
                if (g_srst_s) begin
                    abort_s = 1'b1;
                end else begin
                    valid_s = pend_q;
                    eop_s   = pend_q;
                end
            end
            default: abort_s = 1'b0;
        endcase
    end

`ifdef ROUTER_RDSCHED_PARITY_CHECK_EN
    logic [7:0] xor_q, xor_d;

    // Running XOR over header and payload; the eop byte is compared, not folded in
    always_comb begin
        xor_d = xor_q;
        if (state_q == S_IDLE)      xor_d = 8'h00;
        else if (valid_s && !eop_s) xor_d = xor_q ^ g_data_s;
        else                        xor_d = xor_q;
    end

    // Parity accumulator register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) xor_q <= 8'h00;
        else         xor_q <= xor_d;
    end

    assign perr_s = eop_s && (g_data_s != xor_q);
`else
    assign perr_s = 1'b0;
`endif

    assign read_enb_0 = rd_s && (port_q == 2'd0);
    assign read_enb_1 = rd_s && (port_q == 2'd1);
    assign read_enb_2 = rd_s && (port_q == 2'd2);
    assign out_data   = valid_s ? g_data_s : 8'h00;
    assign out_valid  = valid_s;
    assign out_sop    = sop_s;
    assign out_eop    = eop_s;
    assign out_port   = port_q;
    assign rd_busy    = (state_q != S_IDLE);
    assign abort      = abort_s;
    assign parity_err = perr_s;

endmodule

// File: tb/tb_router_read_scheduler.sv
// Directed bench for router_read_scheduler: three FIFO models, an output log, and one task per scenario.
module tb_router_read_scheduler;

    logic       clk = 1'b0;
    logic       resetn;
    logic       empty_0, empty_1, empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic [7:0] data_out_0 = 8'h00;
    logic [7:0] data_out_1 = 8'h00;
    logic [7:0] data_out_2 = 8'h00;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid, out_sop, out_eop;
    logic [1:0] out_port;
    logic       rd_busy, abort, parity_err;

`ifdef ROUTER_RDSCHED_PARITY_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [3][256];
    logic [7:0] wp [3];
    logic [7:0] rp [3] = '{8'd0, 8'd0, 8'd0};

    int cyc         = 0;
    int rd_cnt [3]  = '{0, 0, 0};
    int rd_blocked  = 0;
    int multi_rd    = 0;
    int last_rd_cyc = 0;
    int abort_cnt   = 0;
    int abort_cyc   = 0;
    int perr_stray  = 0;
    logic [7:0] q_data [$];
    logic       q_sop  [$];
    logic       q_eop  [$];
    logic       q_perr [$];
    logic [1:0] q_port [$];

    always #5 clk = ~clk;

    router_read_scheduler #(.LEN_W(6), .STALL_LIMIT(16)) dut (
        .clk(clk), .resetn(resetn),
        .empty_0(empty_0), .empty_1(empty_1), .empty_2(empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
        .data_out_0(data_out_0), .data_out_1(data_out_1), .data_out_2(data_out_2),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
        .rd_busy(rd_busy), .abort(abort), .parity_err(parity_err)
    );

    assign empty_0 = (rp[0] == wp[0]);
    assign empty_1 = (rp[1] == wp[1]);
    assign empty_2 = (rp[2] == wp[2]);

    // FIFO models: pop on read_enb, data valid next cycle; soft reset flushes
    always @(posedge clk) begin
        if (soft_reset_0) rp[0] <= wp[0];
        else if (read_enb_0) begin data_out_0 <= mem[0][rp[0]]; rp[0] <= rp[0] + 8'd1; end
        if (soft_reset_1) rp[1] <= wp[1];
        else if (read_enb_1) begin data_out_1 <= mem[1][rp[1]]; rp[1] <= rp[1] + 8'd1; end
        if (soft_reset_2) rp[2] <= wp[2];
        else if (read_enb_2) begin data_out_2 <= mem[2][rp[2]]; rp[2] <= rp[2] + 8'd1; end
    end

    // Output log sampled mid-cycle
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (read_enb_0) rd_cnt[0] <= rd_cnt[0] + 1;
        if (read_enb_1) rd_cnt[1] <= rd_cnt[1] + 1;
        if (read_enb_2) rd_cnt[2] <= rd_cnt[2] + 1;
        if (read_enb_0 || read_enb_1 || read_enb_2) begin
            last_rd_cyc <= cyc;
            if (!out_ready) rd_blocked <= rd_blocked + 1;
        end
        if ($countones({read_enb_2, read_enb_1, read_enb_0}) > 1) multi_rd <= multi_rd + 1;
        if (abort) begin
            abort_cnt <= abort_cnt + 1;
            abort_cyc <= cyc;
        end
        if (out_valid) begin
            q_data.push_back(out_data);
            q_sop.push_back(out_sop);
            q_eop.push_back(out_eop);
            q_perr.push_back(parity_err);
            q_port.push_back(out_port);
        end
        if (parity_err && !(out_valid && out_eop)) perr_stray <= perr_stray + 1;
    end

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wp[k]] = b;
        wp[k] = wp[k] + 8'd1;
    endtask

    // {perr, data, sop, eop, port} of logged byte idx; all ones when absent
    function automatic logic [12:0] rec(input int idx);
        if (idx < q_data.size()) return {q_perr[idx], q_data[idx], q_sop[idx], q_eop[idx], q_port[idx]};
        else                     return 13'h1FFF;
    endfunction

    function automatic logic [18:0] all_outs();
        return {read_enb_2, read_enb_1, read_enb_0, out_valid, out_sop, out_eop, out_port,
                rd_busy, abort, parity_err, out_data};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        run_cycles(2);
        resetn = 1'b1;
        run_cycles(1);
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        int rsum;
        #2;
        obs = all_outs();
        n_checks++;
        if (obs !== 19'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 19'd0);
        end
        run_cycles(2);
        resetn = 1'b1;
        run_cycles(3);
        rsum = rd_cnt[0] + rd_cnt[1] + rd_cnt[2];
        n_checks++;
        if ({rd_busy, out_valid} !== 2'b00 || rsum != 0) begin
            n_fail++; $display("FAIL idle_after_reset: busy/valid %b reads %0d expected 00 and 0", {rd_busy, out_valid}, rsum);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0]  exp_b [5];
        logic [12:0] r;
        int s, r0, r1, r2;
        exp_b = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        s = q_data.size(); r0 = rd_cnt[0]; r1 = rd_cnt[1]; r2 = rd_cnt[2];
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(1, exp_b[i]);
        run_cycles(20);
        n_checks++;
        if (rd_cnt[1] - r1 != 5 || rd_cnt[0] != r0 || rd_cnt[2] != r2) begin
            n_fail++; $display("FAIL single_reads: fifo1 %0d others %0d/%0d expected 5 and 0/0",
                               rd_cnt[1] - r1, rd_cnt[0] - r0, rd_cnt[2] - r2);
        end
        n_checks++;
        if (q_data.size() - s != 5) begin
            n_fail++; $display("FAIL single_bytes: got %0d expected 5", q_data.size() - s);
        end
        for (int i = 0; i < 5; i++) begin
            r = rec(s + i);
            n_checks++;
            if (r[12:0] !== {1'b0, exp_b[i], (i == 0), (i == 4), 2'd1}) begin
                n_fail++; $display("FAIL single_byte%0d: got %h expected %h", i, r,
                                   {1'b0, exp_b[i], (i == 0), (i == 4), 2'd1});
            end
        end
        n_checks++;
        if (rd_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: rd_busy %b expected 0", rd_busy);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]  exp9 [9];
        logic [7:0]  exp6 [6];
        logic [11:0] e;
        logic [12:0] r;
        int s;
        do_reset();
        exp9 = '{8'h04, 8'hA0, 8'hA4, 8'h05, 8'hA1, 8'hA4, 8'h06, 8'hA2, 8'hA4};
        s = q_data.size();
        for (int i = 0; i < 9; i++) push(i / 3, exp9[i]);
        run_cycles(40);
        n_checks++;
        if (q_data.size() - s != 9) begin
            n_fail++; $display("FAIL rr_bytes: got %0d expected 9", q_data.size() - s);
        end
        for (int i = 0; i < 9; i++) begin
            r = rec(s + i);
            e = {exp9[i], (i % 3 == 0), (i % 3 == 2), 2'(i / 3)};
            n_checks++;
            if (r[11:0] !== e) begin
                n_fail++; $display("FAIL rr_byte%0d: got %h expected %h", i, r[11:0], e);
            end
        end
        exp6 = '{8'h04, 8'hB0, 8'hB4, 8'h06, 8'hB2, 8'hB4};
        s = q_data.size();
        for (int i = 0; i < 6; i++) push((i < 3) ? 0 : 2, exp6[i]);
        run_cycles(30);
        for (int i = 0; i < 6; i++) begin
            r = rec(s + i);
            e = {exp6[i], (i % 3 == 0), (i % 3 == 2), (i < 3) ? 2'd0 : 2'd2};
            n_checks++;
            if (r[11:0] !== e) begin
                n_fail++; $display("FAIL rr_refill_byte%0d: got %h expected %h", i, r[11:0], e);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0]  exp_b [6];
        logic [11:0] e;
        logic [12:0] r;
        int s, r0, blk;
        exp_b = '{8'h10, 8'h41, 8'h42, 8'h43, 8'h44, 8'h14};
        s = q_data.size(); r0 = rd_cnt[0]; blk = rd_blocked;
        for (int i = 0; i < 6; i++) push(0, exp_b[i]);
        for (int i = 0; i < 48; i++) begin
            out_ready = (i % 4 == 0) || (i % 4 == 3);
            run_cycles(1);
        end
        out_ready = 1'b1;
        run_cycles(5);
        n_checks++;
        if (rd_blocked != blk) begin
            n_fail++; $display("FAIL bp_read_while_not_ready: got %0d expected 0", rd_blocked - blk);
        end
        n_checks++;
        if (rd_cnt[0] - r0 != 6 || q_data.size() - s != 6) begin
            n_fail++; $display("FAIL bp_counts: reads %0d bytes %0d expected 6 and 6", rd_cnt[0] - r0, q_data.size() - s);
        end
        for (int i = 0; i < 6; i++) begin
            r = rec(s + i);
            e = {exp_b[i], (i == 0), (i == 5), 2'd0};
            n_checks++;
            if (r[11:0] !== e) begin
                n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, r[11:0], e);
            end
        end
    endtask

    task automatic test_stall_abort();
        int s, a0, r1, neop;
        s = q_data.size(); a0 = abort_cnt; r1 = rd_cnt[1];
        push(1, 8'h21); push(1, 8'h51); push(1, 8'h52); push(1, 8'h53);
        run_cycles(40);
        n_checks++;
        if (abort_cnt - a0 != 1) begin
            n_fail++; $display("FAIL stall_abort_count: got %0d expected 1", abort_cnt - a0);
        end
        n_checks++;
        if (abort_cyc - last_rd_cyc != 16) begin
            n_fail++; $display("FAIL stall_abort_delay: got %0d expected 16", abort_cyc - last_rd_cyc);
        end
        neop = 0;
        for (int i = s; i < q_data.size(); i++) if (q_eop[i]) neop++;
        n_checks++;
        if (q_data.size() - s != 4 || neop != 0 || rd_cnt[1] - r1 != 4) begin
            n_fail++; $display("FAIL stall_bytes: bytes %0d eops %0d reads %0d expected 4 0 4",
                               q_data.size() - s, neop, rd_cnt[1] - r1);
        end
        n_checks++;
        if (rd_busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_idle: rd_busy %b expected 0", rd_busy);
        end
    endtask

    task automatic test_soft_reset();
        logic        found;
        logic [18:0] obs;
        push(2, 8'h16);
        for (int i = 0; i < 5; i++) push(2, 8'h61 + 8'(i));
        push(2, 8'h77);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid && !out_sop && rd_busy) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL srst_reach_body: timeout got %b expected 1", found);
        end else begin
            #1 soft_reset_0 = 1'b1;
            #1;
            n_checks++;
            if ({abort, out_valid, out_port} !== {1'b0, 1'b1, 2'd2}) begin
                n_fail++; $display("FAIL srst_other_fifo: abort/valid/port %b expected 0110", {abort, out_valid, out_port});
            end
            soft_reset_0 = 1'b0;
            soft_reset_2 = 1'b1;
            #1;
            n_checks++;
            if ({abort, out_valid, out_data, read_enb_2} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
                n_fail++; $display("FAIL srst_abort: abort/valid/data/rd %h expected %h",
                                   {abort, out_valid, out_data, read_enb_2}, {1'b1, 1'b0, 8'h00, 1'b0});
            end
            @(posedge clk);
            #1 soft_reset_2 = 1'b0;
            run_cycles(4);
            n_checks++;
            if ({rd_busy, abort} !== 2'b00) begin
                n_fail++; $display("FAIL srst_idle: busy/abort %b expected 00", {rd_busy, abort});
            end
        end
        push(0, 8'h14);
        for (int i = 0; i < 6; i++) push(0, 8'h71 + 8'(i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (out_valid && !out_sop && rd_busy) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL rstn_reach_body: timeout got %b expected 1", found);
        end else begin
            #1;
            resetn       = 1'b0;
            soft_reset_0 = 1'b1;
            #1;
            obs = all_outs();
            n_checks++;
            if (obs !== 19'd0) begin
                n_fail++; $display("FAIL rstn_async_outputs: got %h expected %h", obs, 19'd0);
            end
            @(posedge clk);
            #1 soft_reset_0 = 1'b0;
            run_cycles(1);
            resetn = 1'b1;
            run_cycles(5);
            n_checks++;
            if (rd_busy !== 1'b0) begin
                n_fail++; $display("FAIL rstn_idle: rd_busy %b expected 0", rd_busy);
            end
        end
    endtask

    task automatic test_parity();
        logic [12:0] r;
        int s;
        s = q_data.size();
        push(0, 8'h08); push(0, 8'h81); push(0, 8'h82); push(0, 8'h0B);
        push(1, 8'h09); push(1, 8'h91); push(1, 8'h92); push(1, 8'h0B);
        run_cycles(30);
        r = rec(s + 3);
        n_checks++;
        if ({r[12], r[2]} !== 2'b01) begin
            n_fail++; $display("FAIL parity_good: perr/eop %b expected 01", {r[12], r[2]});
        end
        r = rec(s + 7);
        n_checks++;
        if ({r[12], r[2], r[1:0]} !== {PERR_EXP, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL parity_bad: perr/eop/port %b expected %b", {r[12], r[2], r[1:0]}, {PERR_EXP, 1'b1, 2'd1});
        end
        n_checks++;
        if (perr_stray != 0 || multi_rd != 0) begin
            n_fail++; $display("FAIL stray_events: perr_stray %0d multi_rd %0d expected 0 0", perr_stray, multi_rd);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        out_ready    = 1'b0;
        soft_reset_0 = 1'b0;
        soft_reset_1 = 1'b0;
        soft_reset_2 = 1'b0;
        for (int k = 0; k < 3; k++) wp[k] = 8'd0;
        test_reset();
        test_single_packet();
        test_round_robin();
        test_back_pressure();
        test_stall_abort();
        test_soft_reset();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
